cache_bank_dp: RTL and testbench
================================

# cache_bank_dp

Parametrised dual-port cache bank, successor to the fixed 8-bit bank: two independent read/write ports on one shared array, with registered reads, same-cycle write-collision arbitration, cross-port write-to-read forwarding and a post-reset clearing sweep. It sits below the cache controller, one instance per bank, with ports A and B driven by the two request pipes.

## Interface

- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words
- clk  input  1  single clock; everything is on the rising edge
- reset  input  1  asynchronous, active-high
- cacheDataIn_A / cacheDataIn_B  input  DATA_WIDTH  write data per port
- cacheAddressIn_A / cacheAddressIn_B  input  ADDR_WIDTH  address per port
- memWrite_A / memWrite_B  input  1  1 = write, 0 = read request
- cacheDataOut_A / cacheDataOut_B  output  DATA_WIDTH  registered read data
- readValid_A / readValid_B  output  1  cacheDataOut_x is valid this cycle
- portA_writtenTo / portB_writtenTo  output  1  write from the previous cycle was committed
- collision  output  1  previous cycle had both ports writing the same address
- initBusy  output  1  clearing sweep in progress; all requests are ignored
- parityErr_A / parityErr_B  output  1  present only with CACHE_BANK_PARITY_EN

## Operation

- Every port samples a request on every edge while initBusy = 0. There is no request-valid input: memWrite_x = 0 is a read.
- Init FSM has two states, SWEEP and READY. Reset forces SWEEP with sweep counter 0. SWEEP writes 0 to word[counter] once per cycle and increments the counter. After word DEPTH-1 is written, the FSM moves to READY and initBusy falls.
- Reset asserted mid-sweep or in READY restarts the sweep from address 0.
- While in SWEEP, port requests are dropped: no write commits, and readValid and writtenTo stay 0.
- Read: data appears on cacheDataOut_x one cycle after the request, with readValid_x = 1.
- Write: the word commits on the edge. writtenTo_x = 1 in the next cycle. The writing port's cacheDataOut_x shows the written data (write-first), and its readValid_x = 0.
- Cross-port forwarding: if port X writes address N and port Y reads N in the same cycle, Y returns the new data.
- Write collision (both ports write the same address):
  - Only the priority port commits.
  - The loser's writtenTo stays 0 next cycle, and the requester must retry.
  - collision = 1 for one cycle.
  - Priority toggles after each collision. Reset value is port A.
- Two writes to different addresses both commit. Two reads of any addresses are both served.
- Addresses are exactly ADDR_WIDTH bits, so there is no out-of-range case. Data is stored unmodified.

## Timing

- Reset values: cacheDataOut_A/B = 0, readValid_A/B = 0, portA/B_writtenTo = 0, collision = 0, parityErr_A/B = 0, initBusy = 1.
- initBusy stays 1 for exactly DEPTH cycles after reset falls. The first request is accepted on the following edge.
- Read latency is 1 cycle. Write acknowledge latency is 1 cycle. Throughput is one request per port per cycle.
- Outputs that are not refreshed hold their values; readValid and writtenTo are single-cycle pulses per request.
- collision and the loser's missing writtenTo appear in the same cycle.

## Configuration

- CACHE_BANK_PARITY_EN defined:
  - Each word stores an extra even-parity bit, computed on write and written as 0 by the sweep.
  - On a read, parity is checked. parityErr_x = 1 in the same cycle as readValid_x when the check fails.
  - A test-only force of the stored parity must be reachable by hierarchical reference.
- CACHE_BANK_PARITY_EN undefined: no parity storage, and the parityErr_A/B ports are absent.

## Test plan

- Reset, then release; DATA_WIDTH = 8, ADDR_WIDTH = 4 -> initBusy high for 16 cycles. A read of address 4 during the sweep gives no readValid. After the sweep, a read of address 4 returns 0.
- Write A addr 4 = 0x02, then read B addr 4 -> portA_writtenTo pulses after 1 cycle. The next cycle, cacheDataOut_B = 0x02 with readValid_B = 1.
- Same cycle: A writes addr 6 = 0x33 while B reads addr 6 -> B returns 0x33 one cycle later.
- Both write addr 7 (A = 0x44, B = 0x55) -> collision = 1 and portA_writtenTo only; word = 0x44. Repeat with A = 0x66, B = 0x77 -> B wins, word = 0x77.
- Reset asserted at sweep count 9, released 2 cycles later -> outputs return to reset values immediately, and the full 16-cycle sweep reruns.
- With CACHE_BANK_PARITY_EN: write addr 2 = 0x01, force its stored parity bit, then read addr 2 -> parityErr_A = 1 with readValid_A.

Source files
------------

// File: rtl/cache_bank_dp.sv
// cache_bank_dp - parametrised dual-port cache bank.
//
// Two independent read/write ports share one word array. Reads are
// registered (1-cycle latency). Writes commit on the edge and are
// acknowledged one cycle later. A write on one port is forwarded to a
// same-cycle read of the same address on the other port. When both ports
// write the same address, only the priority port commits. Priority starts
// at port A and toggles after every collision. After reset, a clearing
// sweep zeroes every word. While the sweep runs, all requests are ignored.
//
// Optional feature macro: CACHE_BANK_PARITY_EN (even parity per word,
// checked on reads, reported on parityErr_A/B).
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   cacheDataIn_A/B                  write data per port
//   cacheAddressIn_A/B               address per port
//   memWrite_A/B                     1 = write, 0 = read
//   cacheDataOut_A/B                 registered read / write-first data
//   readValid_A/B                    read data valid pulse
//   portA_writtenTo/portB_writtenTo  write committed pulse
//   collision                        same-address write collision pulse
//   initBusy                         clearing sweep in progress
//   parityErr_A/B                    parity error pulse (parity build only)
module cache_bank_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] cacheDataIn_A,
    input  logic [DATA_WIDTH-1:0] cacheDataIn_B,
    input  logic [ADDR_WIDTH-1:0] cacheAddressIn_A,
    input  logic [ADDR_WIDTH-1:0] cacheAddressIn_B,
    input  logic                  memWrite_A,
    input  logic                  memWrite_B,
    output logic [DATA_WIDTH-1:0] cacheDataOut_A,
    output logic [DATA_WIDTH-1:0] cacheDataOut_B,
    output logic                  readValid_A,
    output logic                  readValid_B,
    output logic                  portA_writtenTo,
    output logic                  portB_writtenTo,
    output logic                  collision,
    output logic                  initBusy
`ifdef CACHE_BANK_PARITY_EN
    ,
    output logic                  parityErr_A,
    output logic                  parityErr_B
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {SWEEP, READY} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   sweepCnt;
    logic                    prioB;      // 0: port A wins the next collision
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    sameAddrWrite;
    logic                    commitA, commitB;
    logic                    fwdToA, fwdToB;
    logic [DATA_WIDTH-1:0]   rdDataA, rdDataB;

    always_comb begin
        sameAddrWrite = memWrite_A && memWrite_B && (cacheAddressIn_A == cacheAddressIn_B);
        commitA = memWrite_A && !(sameAddrWrite && prioB);
        commitB = memWrite_B && !(sameAddrWrite && !prioB);
        // A same-cycle write on the other port overrides the stored word.
        fwdToA  = commitB && (cacheAddressIn_B == cacheAddressIn_A);
        fwdToB  = commitA && (cacheAddressIn_A == cacheAddressIn_B);
        rdDataA = fwdToA ? cacheDataIn_B : mem[cacheAddressIn_A];
        rdDataB = fwdToB ? cacheDataIn_A : mem[cacheAddressIn_B];
    end

`ifdef CACHE_BANK_PARITY_EN
    logic memPar [DEPTH];
    // Test hook: force to 1 to store an inverted parity bit on writes.
    logic parityFlip;
    logic rdParErrA, rdParErrB;

    assign parityFlip = 1'b0;

    always_comb begin
        rdParErrA = fwdToA ? 1'b0 : ((^mem[cacheAddressIn_A]) ^ memPar[cacheAddressIn_A]);
        rdParErrB = fwdToB ? 1'b0 : ((^mem[cacheAddressIn_B]) ^ memPar[cacheAddressIn_B]);
    end
`endif

    // Array storage: the sweep owns the write port until READY.
    always_ff @(posedge clk) begin
        if (state == SWEEP) begin
            mem[sweepCnt] <= '0;
`ifdef CACHE_BANK_PARITY_EN
            memPar[sweepCnt] <= 1'b0;
`endif
        end else begin
            if (commitA) begin
                mem[cacheAddressIn_A] <= cacheDataIn_A;
`ifdef CACHE_BANK_PARITY_EN
                memPar[cacheAddressIn_A] <= (^cacheDataIn_A) ^ parityFlip;
`endif
            end
            if (commitB) begin
                mem[cacheAddressIn_B] <= cacheDataIn_B;
`ifdef CACHE_BANK_PARITY_EN
                memPar[cacheAddressIn_B] <= (^cacheDataIn_B) ^ parityFlip;
`endif
            end
        end
    end

    // Init FSM and registered port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= SWEEP;
            sweepCnt        <= '0;
            initBusy        <= 1'b1;
            prioB           <= 1'b0;
            cacheDataOut_A  <= '0;
            cacheDataOut_B  <= '0;
            readValid_A     <= 1'b0;
            readValid_B     <= 1'b0;
            portA_writtenTo <= 1'b0;
            portB_writtenTo <= 1'b0;
            collision       <= 1'b0;
`ifdef CACHE_BANK_PARITY_EN
            parityErr_A     <= 1'b0;
            parityErr_B     <= 1'b0;
`endif
        end else begin
            readValid_A     <= 1'b0;
            readValid_B     <= 1'b0;
            portA_writtenTo <= 1'b0;
            portB_writtenTo <= 1'b0;
            collision       <= 1'b0;
`ifdef CACHE_BANK_PARITY_EN
            parityErr_A     <= 1'b0;
            parityErr_B     <= 1'b0;
`endif
            case (state)
                SWEEP: begin
                    sweepCnt <= sweepCnt + 1'b1;
                    if (sweepCnt == '1) begin
                        state    <= READY;
                        initBusy <= 1'b0;
                    end
                end
                READY: begin
                    collision <= sameAddrWrite;
                    if (sameAddrWrite)
                        prioB <= ~prioB;

                    // A losing writer neither acknowledges nor updates its output.
                    if (memWrite_A) begin
                        if (commitA) begin
                            cacheDataOut_A  <= cacheDataIn_A;
                            portA_writtenTo <= 1'b1;
                        end
                    end else begin
                        cacheDataOut_A <= rdDataA;
                        readValid_A    <= 1'b1;
`ifdef CACHE_BANK_PARITY_EN
                        parityErr_A    <= rdParErrA;
`endif
                    end

                    if (memWrite_B) begin
                        if (commitB) begin
                            cacheDataOut_B  <= cacheDataIn_B;
                            portB_writtenTo <= 1'b1;
                        end
                    end else begin
                        cacheDataOut_B <= rdDataB;
                        readValid_B    <= 1'b1;
`ifdef CACHE_BANK_PARITY_EN
                        parityErr_B    <= rdParErrB;
`endif
                    end
                end
                default: state <= SWEEP;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_bank_dp.sv
// Directed bench for cache_bank_dp (DATA_WIDTH=8, ADDR_WIDTH=4).
// Expected outputs are queued when a request is driven, then popped and
// compared one cycle later.
module tb_cache_bank_dp;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] dinA, dinB;
    logic [AW-1:0] addrA, addrB;
    logic          wrA, wrB;
    logic [DW-1:0] doutA, doutB;
    logic          rvA, rvB, wtA, wtB, coll, busy;
`ifdef CACHE_BANK_PARITY_EN
    logic          perA, perB;
`endif

    cache_bank_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .cacheDataIn_A    (dinA),
        .cacheDataIn_B    (dinB),
        .cacheAddressIn_A (addrA),
        .cacheAddressIn_B (addrB),
        .memWrite_A       (wrA),
        .memWrite_B       (wrB),
        .cacheDataOut_A   (doutA),
        .cacheDataOut_B   (doutB),
        .readValid_A      (rvA),
        .readValid_B      (rvB),
        .portA_writtenTo  (wtA),
        .portB_writtenTo  (wtB),
        .collision        (coll),
        .initBusy         (busy)
`ifdef CACHE_BANK_PARITY_EN
        ,
        .parityErr_A      (perA),
        .parityErr_B      (perB)
`endif
    );

    always #5 clk = ~clk;

    // Field ids for scoreboard entries
    localparam int F_DA = 0, F_DB = 1, F_RVA = 2, F_RVB = 3, F_WTA = 4,
                   F_WTB = 5, F_COL = 6, F_BUSY = 7, F_PEA = 8, F_PEB = 9;

    typedef struct {
        int          f;
        logic [31:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [31:0] obs(input int f);
        case (f)
            F_DA:   return 32'(doutA);
            F_DB:   return 32'(doutB);
            F_RVA:  return 32'(rvA);
            F_RVB:  return 32'(rvB);
            F_WTA:  return 32'(wtA);
            F_WTB:  return 32'(wtB);
            F_COL:  return 32'(coll);
            F_BUSY: return 32'(busy);
`ifdef CACHE_BANK_PARITY_EN
            F_PEA:  return 32'(perA);
            F_PEB:  return 32'(perB);
`endif
            default: return 'x;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic expect1(input int f, input logic [31:0] v, input string tag);
        exp_t x;
        x.f = f; x.v = v; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic req(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        wrA = wa; addrA = aa; dinA = da;
        wrB = wb; addrB = ab; dinB = db;
    endtask

    // Advance one edge, then retire every queued expectation.
    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            check(x.tag, obs(x.f), x.v);
        end
    endtask

    task automatic checkResetValues(input string pfx);
        check({pfx, "_doutA"}, 32'(doutA), 0);
        check({pfx, "_doutB"}, 32'(doutB), 0);
        check({pfx, "_rvA"},   32'(rvA),   0);
        check({pfx, "_rvB"},   32'(rvB),   0);
        check({pfx, "_wtA"},   32'(wtA),   0);
        check({pfx, "_wtB"},   32'(wtB),   0);
        check({pfx, "_coll"},  32'(coll),  0);
        check({pfx, "_busy"},  32'(busy),  1);
    endtask

    // Counts edges until initBusy falls, reading addr 4 throughout.
    task automatic sweepCount(input string pfx);
        int n;
        n = 0;
        req(1'b0, 4'd4, 8'h00, 1'b0, 4'd4, 8'h00);
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy === 1'b1) begin
                check({pfx, "_sweep_rvA"}, 32'(rvA), 0);
                check({pfx, "_sweep_rvB"}, 32'(rvB), 0);
            end
        end
        check({pfx, "_sweep_len"}, 32'(n), 32'd16);
    endtask

    initial begin
        reset = 1'b1;
        req(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("rst");
        reset = 1'b0;
        sweepCount("s1");

        // First reads after the sweep: cleared words
        req(1'b0, 4'd4, 8'h00, 1'b0, 4'd15, 8'h00);
        expect1(F_DA, 32'h00, "rd4_A"); expect1(F_RVA, 1, "rd4_rvA");
        expect1(F_DB, 32'h00, "rd15_B"); expect1(F_RVB, 1, "rd15_rvB");
        tick();

        // Write A 4 = 0x02
        req(1'b1, 4'd4, 8'h02, 1'b0, 4'd0, 8'h00);
        expect1(F_WTA, 1, "wr4_wtA"); expect1(F_RVA, 0, "wr4_rvA");
        expect1(F_DA, 32'h02, "wr4_wfA"); expect1(F_COL, 0, "wr4_col");
        tick();

        // Read B 4
        req(1'b0, 4'd0, 8'h00, 1'b0, 4'd4, 8'h00);
        expect1(F_DB, 32'h02, "rdB4"); expect1(F_RVB, 1, "rdB4_rv");
        expect1(F_WTA, 0, "rdB4_wtA_pulse");
        tick();

        // Cross-port forward: A writes 6 = 0x33, B reads 6
        req(1'b1, 4'd6, 8'h33, 1'b0, 4'd6, 8'h00);
        expect1(F_DB, 32'h33, "fwd_AB"); expect1(F_RVB, 1, "fwd_AB_rv");
        expect1(F_WTA, 1, "fwd_AB_wtA");
        tick();

        // Collision 1: A wins
        req(1'b1, 4'd7, 8'h44, 1'b1, 4'd7, 8'h55);
        expect1(F_COL, 1, "col1"); expect1(F_WTA, 1, "col1_wtA");
        expect1(F_WTB, 0, "col1_wtB");
        tick();

        req(1'b0, 4'd7, 8'h00, 1'b0, 4'd7, 8'h00);
        expect1(F_DA, 32'h44, "col1_wordA"); expect1(F_DB, 32'h44, "col1_wordB");
        expect1(F_COL, 0, "col1_pulse");
        tick();

        // Collision 2: B wins
        req(1'b1, 4'd7, 8'h66, 1'b1, 4'd7, 8'h77);
        expect1(F_COL, 1, "col2"); expect1(F_WTA, 0, "col2_wtA");
        expect1(F_WTB, 1, "col2_wtB"); expect1(F_DB, 32'h77, "col2_wfB");
        tick();

        req(1'b0, 4'd7, 8'h00, 1'b0, 4'd6, 8'h00);
        expect1(F_DA, 32'h77, "col2_word"); expect1(F_DB, 32'h33, "rd6_B");
        tick();

        // Two writes to different addresses both commit
        req(1'b1, 4'd8, 8'hAA, 1'b1, 4'd9, 8'hBB);
        expect1(F_WTA, 1, "dual_wtA"); expect1(F_WTB, 1, "dual_wtB");
        expect1(F_COL, 0, "dual_col"); expect1(F_RVB, 0, "dual_rvB");
        expect1(F_DB, 32'hBB, "dual_wfB");
        tick();

        req(1'b0, 4'd9, 8'h00, 1'b0, 4'd8, 8'h00);
        expect1(F_DA, 32'hBB, "dual_rdA"); expect1(F_DB, 32'hAA, "dual_rdB");
        tick();

        // Collision 3: priority back to A
        req(1'b1, 4'd10, 8'hC1, 1'b1, 4'd10, 8'hC2);
        expect1(F_COL, 1, "col3"); expect1(F_WTA, 1, "col3_wtA");
        expect1(F_WTB, 0, "col3_wtB");
        tick();

        // Forward B -> A, and A reads the collision result
        req(1'b0, 4'd11, 8'h00, 1'b1, 4'd11, 8'h5A);
        expect1(F_DA, 32'h5A, "fwd_BA"); expect1(F_WTB, 1, "fwd_BA_wtB");
        tick();

        req(1'b0, 4'd10, 8'h00, 1'b0, 4'd0, 8'h00);
        expect1(F_DA, 32'hC1, "col3_word"); expect1(F_DB, 32'h00, "rd0_B");
`ifdef CACHE_BANK_PARITY_EN
        expect1(F_PEA, 0, "par_ok_A"); expect1(F_PEB, 0, "par_ok_B");
`endif
        tick();

`ifdef CACHE_BANK_PARITY_EN
        force dut.parityFlip = 1'b1;
        req(1'b1, 4'd2, 8'h01, 1'b0, 4'd0, 8'h00);
        expect1(F_WTA, 1, "par_wr");
        tick();
        release dut.parityFlip;
        req(1'b0, 4'd2, 8'h00, 1'b0, 4'd2, 8'h00);
        expect1(F_RVA, 1, "par_rvA"); expect1(F_PEA, 1, "par_errA");
        expect1(F_PEB, 1, "par_errB"); expect1(F_DA, 32'h01, "par_data");
        tick();
`endif

        // Reset from READY: outputs clear asynchronously
        reset = 1'b1;
        #1;
        checkResetValues("rst2");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset again at sweep count 9, held 2 cycles
        repeat (9) @(posedge clk);
        #1;
        check("mid_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        #1;
        checkResetValues("rst3");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sweepCount("s3");

        // Sweep cleared previously written words
        req(1'b0, 4'd7, 8'h00, 1'b0, 4'd9, 8'h00);
        expect1(F_DA, 32'h00, "clr7_A"); expect1(F_DB, 32'h00, "clr9_B");
        expect1(F_RVA, 1, "clr_rvA"); expect1(F_RVB, 1, "clr_rvB");
        tick();

        // Priority resets to A
        req(1'b1, 4'd3, 8'h11, 1'b1, 4'd3, 8'h22);
        expect1(F_COL, 1, "col4"); expect1(F_WTA, 1, "col4_wtA");
        expect1(F_WTB, 0, "col4_wtB");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
